// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction-fetch sequencer for the MIPS core.
// Owns the program counter and issues one fetch per cycle to a synchronous ROM
// that has one cycle of read latency. A one-entry skid buffer holds the
// returned word while decode stalls. Redirects squash wrong-path fetches.
//
// Ports:
//   clock, reset     - single clock, synchronous active-high reset
//   rom_addr         - byte address to the ROM (combinational, redirect-aware)
//   rom_data         - ROM word for the address presented one cycle earlier
//   stall            - decode not ready; output is not consumed this cycle
//   redirect_valid   - taken branch/jump pulse, redirect_pc is the target
//   inst_valid       - inst_out/pc_out carry a live instruction
//   inst_out, pc_out - instruction word and its byte address (0 when not valid)
//   fetch_fault      - pc_out lies beyond the ROM, so the ROM word is aliased
module inst_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        fetch_fault
);

  // Address bits above the ROM's byte range; any set bit means aliasing.
  localparam logic [31:0] FaultMask = ~((32'h1 << (ADDR_WIDTH + 2)) - 32'h1);

  // Skid occupancy: StHold means the skid buffer holds a live instruction.
  typedef enum logic [0:0] {StRun, StHold} skid_state_e;

  skid_state_e skid_state_q, skid_state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_valid_q, inflight_valid_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        skid_valid;
  logic        issue;
  logic        live;
  logic [31:0] redirect_addr;
  logic [31:0] sel_inst;
  logic [31:0] sel_pc;

  // Output path and ROM address select.
  always_comb begin
    skid_valid    = (skid_state_q == StHold);
    issue         = redirect_valid | ~stall;
    // Misaligned targets are silently word-aligned.
    redirect_addr = redirect_pc & 32'hFFFF_FFFC;
    rom_addr      = redirect_valid ? redirect_addr : fetch_pc_q;

    // A redirect kills whatever would have been shown this cycle.
    live     = (skid_valid | inflight_valid_q) & ~redirect_valid;
    sel_inst = skid_valid ? skid_data_q : rom_data;
    sel_pc   = skid_valid ? skid_pc_q : inflight_pc_q;

    inst_valid  = live;
    inst_out    = live ? sel_inst : 32'h0;
    pc_out      = live ? sel_pc : 32'h0;
    fetch_fault = live & (|(sel_pc & FaultMask));
  end

  // Next-state logic.
  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_valid_d = issue;
    inflight_pc_d    = inflight_pc_q;
    skid_state_d     = skid_state_q;
    skid_data_d      = skid_data_q;
    skid_pc_d        = skid_pc_q;

    if (issue) begin
      inflight_pc_d = rom_addr;
      fetch_pc_d    = rom_addr + 32'd4;
    end

    unique case (skid_state_q)
      StRun: begin
        // Capture only happens when issue is blocked, so a second response
        // can never land on a full skid.
        if (!redirect_valid && inflight_valid_q && stall) begin
          skid_state_d = StHold;
          skid_data_d  = rom_data;
          skid_pc_d    = inflight_pc_q;
        end
      end
      StHold: begin
        if (redirect_valid || !stall) begin
          skid_state_d = StRun;
        end
      end
      default: skid_state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q       <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= 32'h0;
      skid_state_q     <= StRun;
      skid_data_q      <= 32'h0;
      skid_pc_q        <= 32'h0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      skid_state_q     <= skid_state_d;
      skid_data_q      <= skid_data_d;
      skid_pc_q        <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed stimulus, accepted instructions are
// checked by a scoreboard monitor; boundary cycles are checked inline.
module tb_inst_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        fetch_fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  inst_fetch_ctrl #(
    .ADDR_WIDTH(8),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .pc_out        (pc_out),
    .fetch_fault   (fetch_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Distinct word per ROM index.
  function automatic logic [31:0] rom_word(input int unsigned idx);
    logic [7:0] b;
    b = idx[7:0];
    return {8'hA5, b, ~b, 8'h3C};
  endfunction

  // 256-word synchronous ROM, aliasing above 0x3FF.
  always @(posedge clock) rom_data <= rom_word({24'h0, rom_addr[9:2]});

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
    exp_t e;
    e.pc    = pc;
    e.inst  = inst;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait to mid-cycle.
  task automatic cyc(input logic rst, input logic st, input logic rv, input logic [31:0] rpc);
    @(posedge clock);
    #1;
    reset          = rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clock);
  endtask

  // Scoreboard monitor: every accepted instruction must match the queue head.
  always @(negedge clock) begin
    if (mon_en && inst_valid === 1'b1 && stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_unexpected: got pc %h, expected no accept", pc_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("acc_pc", pc_out, mon_e.pc);
        chk("acc_inst", inst_out, mon_e.inst);
        chk("acc_fault", 32'(fetch_fault), 32'(mon_e.fault));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    mon_en = 1'b1;

    // Straight-line fetch, then a 3-cycle stall on pc 8.
    push(32'h0, rom_word(0), 1'b0);
    push(32'h4, rom_word(1), 1'b0);
    push(32'h8, rom_word(2), 1'b0);
    push(32'hC, rom_word(3), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);   // cycle 0
    chk("c0_valid", 32'(inst_valid), 32'h0);
    chk("c0_rom_addr", rom_addr, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c1_rom_addr", rom_addr, 32'h4);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c2_rom_addr", rom_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk("stall_valid", 32'(inst_valid), 32'h1);
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_inst", inst_out, rom_word(2));
      chk("stall_rom_addr", rom_addr, 32'hC);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);   // release: 8 accepted, C issued
    chk("rel_rom_addr", rom_addr, 32'hC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);   // C accepted

    // Fill the skid with pc 0x10, then redirect to 0x40 under stall.
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("fill_pc", pc_out, 32'h10);
    push(32'h40, rom_word(16), 1'b0);
    push(32'h44, rom_word(17), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h40);
    chk("redir_valid", 32'(inst_valid), 32'h0);
    chk("redir_rom_addr", rom_addr, 32'h40);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("tgt_valid", 32'(inst_valid), 32'h1);
    chk("tgt_pc", pc_out, 32'h40);
    chk("tgt_rom_addr", rom_addr, 32'h44);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("tgt_hold_pc", pc_out, 32'h40);
    chk("tgt_hold_inst", inst_out, rom_word(16));
    cyc(1'b0, 1'b0, 1'b0, 32'h0);   // 0x40 accepted
    cyc(1'b0, 1'b0, 1'b0, 32'h0);   // 0x44 accepted
    chk("next_pc", pc_out, 32'h44);

    // Misaligned redirect target.
    push(32'h40, rom_word(16), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h43);
    chk("mis_rom_addr", rom_addr, 32'h40);
    chk("mis_valid", 32'(inst_valid), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

    // ROM boundary: 0x3FC in range, 0x400 aliases to word 0.
    push(32'h3FC, rom_word(255), 1'b0);
    push(32'h400, rom_word(0), 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h3FC);
    chk("edge_rom_addr", rom_addr, 32'h3FC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("edge_fault_lo", 32'(fetch_fault), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("edge_fault_hi", 32'(fetch_fault), 32'h1);
    chk("edge_alias_inst", inst_out, rom_word(0));
    cyc(1'b0, 1'b1, 1'b0, 32'h0);   // 0x404 captured into skid
    chk("skid_pc", pc_out, 32'h404);
    chk("skid_fault", 32'(fetch_fault), 32'h1);

    // One-cycle reset with the skid full and stall high.
    push(32'h0, rom_word(0), 1'b0);
    push(32'h4, rom_word(1), 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("postrst_valid", 32'(inst_valid), 32'h0);
    chk("postrst_rom_addr", rom_addr, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("restart_valid", 32'(inst_valid), 32'h1);
    chk("restart_pc", pc_out, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the synchronous instruction ROM. It issues one fetch per cycle and absorbs the ROM's one-cycle registered read latency. It holds fetched instructions in a one-entry skid buffer while the decode stage stalls, and it squashes wrong-path fetches on branch or jump redirects. It sits between the instruction ROM and the decode stage of the MIPS core.

## Interface
Parameters:
- ADDR_WIDTH, 8, log2 of ROM depth in words; it must match the ROM instance.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- rom_addr  out  32  byte address presented to the ROM.
- rom_data  in  32  ROM read data, already byte-swapped; it belongs to the address presented one cycle earlier.
- stall  in  1  decode not ready; the instruction on the output is not consumed this cycle.
- redirect_valid  in  1  branch or jump taken; single-cycle pulse.
- redirect_pc  in  32  redirect target byte address.
- inst_valid  out  1  inst_out/pc_out hold a live instruction.
- inst_out  out  32  instruction word.
- pc_out  out  32  byte address of inst_out.
- fetch_fault  out  1  pc_out lies beyond the ROM: pc_out[31:ADDR_WIDTH+2] != 0, so the ROM aliases the word.

## Operation
- State:
  - fetch_pc: next address to issue.
  - inflight_valid/inflight_pc: request issued last cycle.
  - skid_valid/skid_data/skid_pc: one-entry holding buffer.
- Address select:
  - rom_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : fetch_pc. This is combinational, so a redirect target is read the same cycle.
  - Misaligned redirect targets have bits [1:0] cleared silently.
- Issue rule:
  - issue = redirect_valid | ~stall.
  - On issue: inflight_valid<=1, inflight_pc<=rom_addr, fetch_pc<=rom_addr+4.
  - PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
  - Without issue: fetch_pc holds and inflight_valid<=0. The ROM still reads, but the result is discarded.
- Output select:
  - Skid has priority over the in-flight response.
  - live = (skid_valid | inflight_valid) & ~redirect_valid.
  - inst_valid = live.
  - inst_out/pc_out = skid_valid ? skid_* : rom_data/inflight_pc.
  - inst_out, pc_out and fetch_fault are all forced to 0 when inst_valid=0.
- Accept: an accept occurs on inst_valid & ~stall.
  - If the skid supplied the output, skid_valid<=0.
  - If the in-flight response supplied it, the response is consumed.
- Capture: when the in-flight response is live, the skid is empty and stall=1, then skid<={rom_data, inflight_pc} and skid_valid<=1.
  - Because issue stops whenever stall=1 without redirect, a second response can never arrive while the skid is full. Overflow is impossible by construction.
- Redirect (priority over everything except reset):
  - skid_valid<=0 and the in-flight response is dropped in the same cycle.
  - inst_valid is 0 that cycle.
  - The target is issued regardless of stall.
- Effective state machine on skid occupancy:
  - RUN (skid empty) -> HOLD on capture.
  - HOLD -> RUN on accept or redirect.
  - Any state -> RUN (flushed) on reset.

## Timing
- Reset values:
  - fetch_pc=RESET_PC, inflight_valid=0, skid_valid=0, skid_data=0, skid_pc=0.
  - inst_valid=0, inst_out=0, pc_out=0, fetch_fault=0.
  - rom_addr=RESET_PC while reset is high (absent redirect).
- Cycle 0 is the first cycle with reset low: RESET_PC is issued. In cycle 1, inst_valid=1 with pc_out=RESET_PC.
- Fetch-to-output latency is 1 cycle. Throughput is 1 instruction per cycle with no stall.
- Stall release:
  - The held instruction is accepted in the release cycle, and the next address is issued in that same cycle.
  - The following instruction is valid the next cycle, with zero bubbles.
- Redirect: one dead cycle (the redirect cycle itself); the target is valid the next cycle.
- Reset mid-operation: asserting reset in any state clears the skid and in-flight state at the next edge. inst_valid=0 from the cycle after reset is sampled.
- Simultaneous redirect and stall: the target is issued, then captured into the skid the next cycle if stall persists.

## Test plan
- Reset release, stall=0, ROM words 0..7 distinct:
  - rom_addr sequence 0,4,8,... from cycle 0.
  - inst_valid=1 from cycle 1 with pc_out 0,4,8,... and inst_out equal to the matching words.
  - No gaps.
- Stall=1 for 3 cycles while pc_out=8:
  - inst_out and pc_out hold rom[2]/8 all 3 cycles; rom_addr stays 0xC.
  - After release, the next cycle shows pc 0xC; no duplicate or skipped word.
- redirect_valid with redirect_pc=0x40 while stall=1 and the skid full:
  - inst_valid=0 in the redirect cycle; rom_addr=0x40 that cycle.
  - The next cycle shows pc_out=0x40, held while stall=1, then 0x44 follows.
- redirect_pc=0x43:
  - rom_addr=0x40; the next cycle shows pc_out=0x40 with inst_out=rom[16].
- ADDR_WIDTH=8, redirect to 0x3FC:
  - pc 0x3FC has fetch_fault=0.
  - pc 0x400 has fetch_fault=1 and inst_out=rom[0].
- Reset asserted for 1 cycle while the skid is full and stall=1:
  - inst_valid=0 the next cycle.
  - The fetch restarts at RESET_PC and the first valid output is pc_out=RESET_PC one cycle after reset deasserts.
